// File: rtl/fir_folded_mac_pkg.sv
// Shared types and helpers for the folded FIR: FSM state encoding, accumulator
// width rule, and the output reduction (wrap or saturate) used by fir_folded_mac.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Reduce a wide signed value to w bits: clamp when sat is set, else two's-complement wrap.
  function automatic logic signed [63:0] reduce_out(input logic signed [63:0] v,
                                                    input int unsigned w,
                                                    input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat) begin
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
    end
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

endpackage

// File: rtl/fir_folded_mac_if.sv
// Sample-in / sample-out valid-ready streams plus the coefficient write port.
interface fir_folded_mac_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_data;
  logic                      coef_we;
  logic [$clog2(TAPS)-1:0]   coef_addr;
  logic signed [COEF_W-1:0]  coef_data;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_folded_mac_coef_bank.sv
// TAPS x COEF_W coefficient register file: synchronous write only while the
// filter is idle, combinational read at the current MAC index.
module fir_coef_bank #(
  parameter int COEF_W = 8,
  parameter int TAPS   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      idle,
  input  logic [$clog2(TAPS)-1:0]   addr,
  input  logic signed [COEF_W-1:0]  wdata,
  input  logic [$clog2(TAPS)-1:0]   raddr,
  output logic signed [COEF_W-1:0]  rdata
);
  logic signed [COEF_W-1:0] mem [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we && idle && (int'(addr) < TAPS)) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_folded_mac.sv
// Folded FIR: one MAC unit walks TAPS products per sample, then holds the result.
// Build option: define FIR_FOLDED_SAT_EN to saturate the output instead of wrapping.
module fir_folded_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int FRAC   = 7,
  parameter int ACC_W  = acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  fir_folded_mac_if.slave    bus,
  output logic               busy
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
`ifdef FIR_FOLDED_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  state_t                   state, state_nx;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [COEF_W-1:0] coef_k;
  logic signed [PW-1:0]     prod;
  logic                     accept;
  logic                     last;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.coef_we),
    .idle  (state == IDLE),
    .addr  (bus.coef_addr),
    .wdata (bus.coef_data),
    .raddr (k),
    .rdata (coef_k)
  );

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (k == KW'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nx = MAC;
      MAC:     if (last)          state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == HOLD);
    busy          = (state != IDLE);
  end

  assign prod = PW'(x[k]) * PW'(coef_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) x[i] <= '0;
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      x[0] <= bus.in_data;
      for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
      acc <= '0;
      k   <= '0;
    end else if (state == MAC) begin
      acc <= acc + ACC_W'(prod);
      k   <= last ? '0 : k + 1'b1;
    end
  end

  // Scale once on the full-precision sum; >>> floors toward -inf.
  assign shifted      = acc >>> FRAC;
  assign bus.out_data = DATA_W'(reduce_out(64'(shifted), DATA_W, SAT));

endmodule

// File: tb/tb_fir_folded_mac.sv
// Directed bench for fir_folded_mac. COEF_W is 9 so the 128 tap of the impulse
// coefficient set is representable; outputs remain 8-bit.
module tb_fir_folded_mac;
  localparam int DATA_W = 8;
  localparam int COEF_W = 9;
  localparam int TAPS   = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_folded_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus ();

  fir_folded_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .FRAC   (7)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = COEF_W'(d);
    tick();
    bus.coef_we   = 1'b0;
  endtask

  // Waits (bounded) for out_valid; n is edges waited after the caller's last tick.
  task automatic wait_out(output int res, output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got=0 want=1");
    end
    res = int'(bus.out_data);
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // lat = edge index (from the accepting edge) at which the consumer first samples out_valid=1.
  task automatic run_sample(input int d, output int res, output int lat);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    tick();
    bus.in_valid = 1'b0;
    wait_out(res, n);
    lat = n + 1;
    consume();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_impulse;
    int exp_out [8] = '{15, 31, 47, 63, 79, 95, 111, 127};
    int res, lat;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16 * (i + 1));
    for (int n = 0; n < TAPS; n++) begin
      run_sample((n == 0) ? 127 : 0, res, lat);
      checks++; if (res !== exp_out[n]) begin errors++; $display("FAIL impulse_out[%0d] got=%0d want=%0d", n, res, exp_out[n]); end
      checks++; if (lat !== TAPS + 1) begin errors++; $display("FAIL impulse_latency[%0d] got=%0d want=%0d", n, lat, TAPS + 1); end
    end
  endtask

  task automatic test_negative_floor;
    int res, lat;
    do_reset();
    write_coef(0, 1);
    run_sample(-1, res, lat);
    checks++; if (res !== -1) begin errors++; $display("FAIL floor_minus1 got=%0d want=-1", res); end
    write_coef(0, 127);
    run_sample(-128, res, lat);
    checks++; if (res !== -127) begin errors++; $display("FAIL floor_minus128 got=%0d want=-127", res); end
  endtask

  task automatic test_overflow;
    int res, lat;
`ifdef FIR_FOLDED_SAT_EN
    int exp8 = 127;
`else
    int exp8 = -16;
`endif
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
    for (int n = 0; n < TAPS; n++) begin
      run_sample(127, res, lat);
      if (n == 0) begin
        checks++; if (res !== 126) begin errors++; $display("FAIL overflow_first got=%0d want=126", res); end
      end
    end
    checks++; if (res !== exp8) begin errors++; $display("FAIL overflow_eighth got=%0d want=%0d", res, exp8); end
  endtask

  task automatic test_backpressure;
    int res, n, lat;
    do_reset();
    write_coef(0, 127);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd100;
    tick();
    bus.in_valid = 1'b0;
    wait_out(res, n);
    checks++; if (res !== 99) begin errors++; $display("FAIL bp_first_out got=%0d want=99", res); end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'sd55;
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b want=1", c, bus.out_valid); end
      checks++; if (int'(bus.out_data) !== 99) begin errors++; $display("FAIL bp_data[%0d] got=%0d want=99", c, bus.out_data); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    consume();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
    // x[1] must still be 100: none of the pulses held off during HOLD was taken.
    write_coef(0, 0);
    write_coef(1, 127);
    run_sample(0, res, lat);
    checks++; if (res !== 99) begin errors++; $display("FAIL bp_no_accept got=%0d want=99", res); end
  endtask

  task automatic test_coef_write_busy;
    int res, n, lat;
    do_reset();
    write_coef(0, 50);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd64;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 9'sd100;
    tick();
    bus.coef_we = 1'b0;
    wait_out(res, n);
    checks++; if (res !== 25) begin errors++; $display("FAIL busy_write_result got=%0d want=25", res); end
    consume();
    run_sample(64, res, lat);
    checks++; if (res !== 25) begin errors++; $display("FAIL busy_write_bank_kept got=%0d want=25", res); end
    write_coef(0, 100);
    run_sample(64, res, lat);
    checks++; if (res !== 50) begin errors++; $display("FAIL idle_write_applies got=%0d want=50", res); end
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 9'sd2;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'sd64;
    tick();
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    wait_out(res, n);
    checks++; if (res !== 1) begin errors++; $display("FAIL same_cycle_write got=%0d want=1", res); end
    consume();
  endtask

  task automatic test_reset_mid_mac;
    int res, lat;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd100;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mac_busy got=%b want=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'sd0) begin errors++; $display("FAIL mid_rst_out_data got=%0d want=0", bus.out_data); end
    run_sample(127, res, lat);
    checks++; if (res !== 0) begin errors++; $display("FAIL mid_rst_bank_cleared got=%0d want=0", res); end
    // x[2] would hold the pre-reset 100 if the delay line were not cleared.
    write_coef(2, 127);
    run_sample(0, res, lat);
    checks++; if (res !== 0) begin errors++; $display("FAIL mid_rst_delay_cleared got=%0d want=0", res); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_impulse();
    test_negative_floor();
    test_overflow();
    test_backpressure();
    test_coef_write_busy();
    test_reset_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
